// File: rtl/led_sched_pkg.sv
// Shared types and constants for the led_sched time-slice LED arbiter.
package led_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GUARD = 2'd2
  } state_t;

  localparam int DWELL_DEF = 1048576;
  localparam int GUARD_DEF = 16;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Wide enough for both phases, never narrower than 20 bits.
  function automatic int cnt_width(input int dwell, input int guard);
    int w;
    w = 20;
    if ($clog2(dwell) > w) w = $clog2(dwell);
    if ($clog2(guard) > w) w = $clog2(guard);
    return w;
  endfunction

endpackage

// File: rtl/led_sched_rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_id,
// wrapping modulo NREQ, so last_id itself is considered last.
module rr_pick
  import led_sched_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int ID_W = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] last_id,
  output logic            valid,
  output logic [ID_W-1:0] next_id
);

  logic [2*NREQ-1:0] w_dbl;
  logic [2*NREQ-1:0] w_rot;
  logic [2*NREQ-1:0] w_tmp;
  int                w_idx;

  assign w_dbl = {req, req};
  assign w_rot = w_dbl >> (int'(last_id) + 1);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    valid   = 1'b0;
    next_id = '0;
    w_tmp   = '0;
    w_idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_tmp = w_rot >> k;
      if (!valid && w_tmp[0]) begin
        valid = 1'b1;
        w_idx = int'(last_id) + 1 + k;
        if (w_idx >= NREQ) w_idx = w_idx - NREQ;
        next_id = ID_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/led_sched.sv
// Time-sliced LED scheduler: round-robin grants of DWELL cycles separated by
// GUARD blank cycles. Optional PWM dimming via macro LED_SCHED_PWM_EN.
module led_sched
  import led_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int LED_W = 4,
  parameter int DWELL = DWELL_DEF,
  parameter int GUARD = GUARD_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*LED_W-1:0] req_led,
  output logic [NREQ-1:0]       gnt,
  output logic [LED_W-1:0]      led,
  output logic                  busy
`ifdef LED_SCHED_PWM_EN
  ,
  input  logic [7:0]            duty
`endif
);

  localparam int ID_W  = id_width(NREQ);
  localparam int CNT_W = cnt_width(DWELL, GUARD);

  // The GUARD parameter hides the package's GUARD state, so alias the states.
  localparam state_t ST_IDLE  = led_sched_pkg::IDLE;
  localparam state_t ST_GRANT = led_sched_pkg::GRANT;
  localparam state_t ST_GUARD = led_sched_pkg::GUARD;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [ID_W-1:0]    r_id;
  logic [ID_W-1:0]    r_last;
  logic [LED_W-1:0]   r_led;

  logic               w_pick_valid;
  logic [ID_W-1:0]    w_pick_id;
  logic               w_req_cur;
  logic               w_dwell_done;
  logic               w_guard_done;
  logic [LED_W-1:0]   w_slice;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req),
    .last_id (r_last),
    .valid   (w_pick_valid),
    .next_id (w_pick_id)
  );

  assign w_req_cur    = req[r_id];
  assign w_dwell_done = (r_cnt == CNT_W'(DWELL - 1));
  assign w_guard_done = (r_cnt == CNT_W'(GUARD - 1));
  assign w_slice      = LED_W'(req_led >> (int'(r_id) * LED_W));

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_pick_valid) w_next = ST_GRANT;
      ST_GRANT: if (!w_req_cur || w_dwell_done) w_next = ST_GUARD;
      ST_GUARD: if (w_guard_done) w_next = w_pick_valid ? ST_GRANT : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt  = '0;
    busy = 1'b0;
    if (r_state == ST_GRANT) gnt[r_id] = 1'b1;
    if (r_state != ST_IDLE)  busy = 1'b1;
  end

  // Counter clears on any state change; the pattern register only holds data
  // while the grant continues, so GUARD/IDLE see zero immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt  <= '0;
      r_id   <= '0;
      r_last <= ID_W'(NREQ - 1);
      r_led  <= '0;
    end else begin
      if (w_next != r_state)        r_cnt <= '0;
      else if (r_state != ST_IDLE)  r_cnt <= r_cnt + CNT_W'(1);
      if (r_state != ST_GRANT && w_next == ST_GRANT) r_id <= w_pick_id;
      if (r_state == ST_GRANT && w_next != ST_GRANT) r_last <= r_id;
      r_led <= (r_state == ST_GRANT && w_next == ST_GRANT) ? w_slice : '0;
    end
  end

`ifdef LED_SCHED_PWM_EN
  logic [7:0] r_pwm;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_pwm <= '0;
    else         r_pwm <= r_pwm + 8'd1;
  end

  assign led = (r_pwm < duty) ? r_led : '0;
`else
  assign led = r_led;
`endif

endmodule

// File: tb/tb_led_sched.sv
// Self-checking bench for led_sched (NREQ=4, LED_W=4, DWELL=8, GUARD=2):
// directed vector table, hand-written corner sequences, randomized model check.
module tb_led_sched;

  localparam int NREQ  = 4;
  localparam int LED_W = 4;
  localparam int DWELL = 8;
  localparam int GUARD = 2;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] req_led = '0;
  logic [3:0]  gnt;
  logic [3:0]  led;
  logic        busy;
`ifdef LED_SCHED_PWM_EN
  logic [7:0]  duty = 8'hFF;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  led_sched #(.NREQ(NREQ), .LED_W(LED_W), .DWELL(DWELL), .GUARD(GUARD)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .req_led (req_led),
    .gnt     (gnt),
    .led     (led),
    .busy    (busy)
`ifdef LED_SCHED_PWM_EN
    ,
    .duty    (duty)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int         m_owner;   // granted requester, -1 when none
  int         m_age;     // cycles already spent in the current slice
  int         m_blank;   // blank cycles still to show
  int         m_last;
  logic [3:0] m_led;
  int         m_pwm;

  function automatic logic [3:0] slice_of(input logic [15:0] rl, input int idx);
    return 4'(rl >> (idx * LED_W));
  endfunction

  function automatic int pick(input logic [3:0] r, input int last);
    int idx;
    logic [3:0] sh;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (last + k) % NREQ;
      sh  = r >> idx;
      if (sh[0]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_age   = 0;
    m_blank = 0;
    m_last  = NREQ - 1;
    m_led   = '0;
    m_pwm   = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [15:0] rl);
    int p;
    logic [3:0] sh;
    m_pwm = (m_pwm + 1) % 256;
    if (m_owner >= 0) begin
      sh = r >> m_owner;
      if (!sh[0] || m_age == DWELL - 1) begin
        m_last  = m_owner;
        m_owner = -1;
        m_blank = GUARD;
        m_led   = '0;
      end else begin
        m_age++;
        m_led = slice_of(rl, m_owner);
      end
    end else begin
      m_led = '0;
      if (m_blank > 0) m_blank--;
      if (m_blank == 0) begin
        p = pick(r, m_last);
        if (p >= 0) begin
          m_owner = p;
          m_age   = 0;
        end
      end
    end
  endtask

  function automatic logic [3:0] exp_gnt();
    return (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
  endfunction

  function automatic logic [3:0] exp_led();
`ifdef LED_SCHED_PWM_EN
    return (m_pwm < int'(duty)) ? m_led : 4'b0000;
`else
    return m_led;
`endif
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    logic [3:0]  r;
    logic [15:0] rl;
    r  = req;
    rl = req_led;
    @(posedge clk);
    model_step(r, rl);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [15:0] req_led;
    logic [3:0]  gnt;
    logic [3:0]  led;
    logic        busy;
  } vec_t;

  vec_t tbl[12];

  function automatic vec_t mk(input logic [3:0] g, input logic [3:0] l, input logic b);
    vec_t v;
    v.req     = 4'b0001;
    v.req_led = 16'h5C3A;
    v.gnt     = g;
    v.led     = l;
    v.busy    = b;
    return v;
  endfunction

  initial begin
    int sl;
    int pos;
    logic [3:0] eg;
    logic [3:0] el;

    // Sole requester 0, pattern 1010: 8-cycle slice, 2 blank, re-grant.
    tbl[0]  = mk(4'b0001, 4'h0, 1'b1);
    for (int i = 1; i < 8; i++) tbl[i] = mk(4'b0001, 4'hA, 1'b1);
    tbl[8]  = mk(4'b0000, 4'h0, 1'b1);
    tbl[9]  = mk(4'b0000, 4'h0, 1'b1);
    tbl[10] = mk(4'b0001, 4'h0, 1'b1);
    tbl[11] = mk(4'b0001, 4'hA, 1'b1);

    do_reset();
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_led", 32'(led), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    for (int i = 0; i < 12; i++) begin
      req     = tbl[i].req;
      req_led = tbl[i].req_led;
      tick();
      check($sformatf("tbl%0d_gnt", i + 1), 32'(gnt), 32'(tbl[i].gnt));
      check($sformatf("tbl%0d_led", i + 1), 32'(led), 32'(tbl[i].led));
      check($sformatf("tbl%0d_busy", i + 1), 32'(busy), 32'(tbl[i].busy));
    end

    // All requesting: order 0,1,2,3,0 with 8-cycle slices and 2 blanks.
    do_reset();
    req     = 4'b1111;
    req_led = 16'h4321;
    for (int c = 1; c <= 50; c++) begin
      tick();
      pos = (c - 1) % 10;
      sl  = ((c - 1) / 10) % 4;
      eg  = (pos < 8) ? (4'b0001 << sl) : 4'b0000;
      el  = (pos >= 1 && pos <= 7) ? 4'(sl + 1) : 4'h0;
      check($sformatf("rr_c%0d_gnt", c), 32'(gnt), 32'(eg));
      check($sformatf("rr_c%0d_led", c), 32'(led), 32'(el));
    end

    // Requester 2 drops in its third grant cycle: guard, then idle.
    do_reset();
    req     = 4'b0100;
    req_led = 16'h0F00;
    for (int c = 1; c <= 3; c++) begin
      tick();
      check($sformatf("drop_c%0d_gnt", c), 32'(gnt), 32'h4);
    end
    check("drop_c3_led", 32'(led), 32'hF);
    req = 4'b0000;
    tick();
    check("drop_c4_gnt", 32'(gnt), 32'h0);
    check("drop_c4_busy", 32'(busy), 32'h1);
    check("drop_c4_led", 32'(led), 32'h0);
    tick();
    check("drop_c5_busy", 32'(busy), 32'h1);
    tick();
    check("drop_c6_busy", 32'(busy), 32'h0);
    check("drop_c6_gnt", 32'(gnt), 32'h0);

    // Async reset mid-grant, then index 0 must be served first.
    do_reset();
    req     = 4'b0001;
    req_led = 16'h000F;
    repeat (14) tick();
    check("arst_pre_gnt", 32'(gnt), 32'h1);
    check("arst_pre_led", 32'(led), 32'hF);
    #2;
    resetn = 1'b0;
    model_reset();
    #1;
    check("arst_gnt", 32'(gnt), 32'h0);
    check("arst_led", 32'(led), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    req = 4'b1111;
    do_reset();
    tick();
    check("arst_first_gnt", 32'(gnt), 32'h1);

    // Requester 1 drops during the guard after slice 0: re-grant goes to 0.
    do_reset();
    req     = 4'b0011;
    req_led = 16'h00C5;
    repeat (9) tick();
    check("gdrop_c9_gnt", 32'(gnt), 32'h0);
    check("gdrop_c9_busy", 32'(busy), 32'h1);
    req = 4'b0001;
    tick();
    tick();
    check("gdrop_c11_gnt", 32'(gnt), 32'h1);

    // Randomized run against the reference model.
    do_reset();
`ifdef LED_SCHED_PWM_EN
    duty = 8'd64;
`endif
    for (int c = 0; c < 900; c++) begin
      if ($urandom_range(0, 5) == 0) req = 4'($urandom);
      req_led = 16'($urandom);
`ifdef LED_SCHED_PWM_EN
      if ($urandom_range(0, 99) == 0) begin
        case ($urandom_range(0, 3))
          0:       duty = 8'd0;
          1:       duty = 8'd255;
          2:       duty = 8'd64;
          default: duty = 8'($urandom);
        endcase
      end
`endif
      tick();
      check($sformatf("rnd%0d_gnt", c), 32'(gnt), 32'(exp_gnt()));
      check($sformatf("rnd%0d_led", c), 32'(led), 32'(exp_led()));
      check($sformatf("rnd%0d_busy", c), 32'(busy),
            32'((m_owner >= 0) || (m_blank > 0)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
